// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the two-port memory arbiter (mem_arbiter).
// Access-size codes, FSM state encoding, priority modes and the latched command record.
package mem_arb_pkg;

  localparam logic [1:0] MC_WORD = 2'b00;
  localparam logic [1:0] MC_HALF = 2'b01;
  localparam logic [1:0] MC_BYTE = 2'b10;

  localparam int PRIO_RR    = 0;
  localparam int PRIO_FIXED = 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_DONE   = 2'b10
  } state_t;

  typedef struct packed {
    logic        wr;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lsb);
    return ((size == MC_WORD) && (lsb != 2'b00)) || ((size == MC_HALF) && lsb[0]);
  endfunction

endpackage

// File: rtl/mem_arb_rr_arb2.sv
// rr_arb2: combinational two-way pick between the CPU port (0) and the secondary master (1).
// Round-robin uses the last granted port; fixed priority always favours port 0.
module rr_arb2
  import mem_arb_pkg::*;
#(
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic [1:0] req,
  input  logic       last_gnt,
  output logic       gnt_id,
  output logic       valid
);

  always_comb begin
    valid  = |req;
    gnt_id = 1'b0;
    if (req == 2'b10) begin
      gnt_id = 1'b1;
    end else if (req == 2'b11) begin
      gnt_id = (PRIO_MODE == PRIO_FIXED) ? 1'b0 : ~last_gnt;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises two masters onto the shared MEM32, holding strobes for MEM_LAT cycles.
// Optional build macro MEM_ARB_ALIGN_CHK_EN: misaligned word/half commands complete at once with err.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT   = 2,
  parameter int PRIO_MODE = PRIO_RR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        c0_req,
  input  logic        c0_wr,
  input  logic [1:0]  c0_size,
  input  logic        c0_sign,
  input  logic [31:0] c0_addr,
  input  logic [31:0] c0_wdata,
  output logic        c0_ack,
  output logic [31:0] c0_rdata,
  output logic        c0_err,
  input  logic        c1_req,
  input  logic        c1_wr,
  input  logic [1:0]  c1_size,
  input  logic        c1_sign,
  input  logic [31:0] c1_addr,
  input  logic [31:0] c1_wdata,
  output logic        c1_ack,
  output logic [31:0] c1_rdata,
  output logic        c1_err,
  output logic        mem_w,
  output logic        mem_r,
  output logic [1:0]  mem_c,
  output logic        mem_s,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        gnt_id
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;

  state_t           state_q, state_d;
  cmd_t             cmd_q, cmd0, cmd1, cmd_pick;
  logic             gnt_q, last_q, err_q;
  logic             arb_gnt, arb_valid, pick_mis;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      rdata0_q, rdata1_q;

  assign cmd0     = '{wr: c0_wr, size: c0_size, sign: c0_sign, addr: c0_addr, wdata: c0_wdata};
  assign cmd1     = '{wr: c1_wr, size: c1_size, sign: c1_sign, addr: c1_addr, wdata: c1_wdata};
  assign cmd_pick = arb_gnt ? cmd1 : cmd0;

  rr_arb2 #(.PRIO_MODE(PRIO_MODE)) u_arb (
    .req      ({c1_req, c0_req}),
    .last_gnt (last_q),
    .gnt_id   (arb_gnt),
    .valid    (arb_valid)
  );

`ifdef MEM_ARB_ALIGN_CHK_EN
  assign pick_mis = misaligned(cmd_pick.size, cmd_pick.addr[1:0]);
`else
  assign pick_mis = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Strobes and acks decode straight from the state register so an async reset drops them at once.
  always_comb begin
    state_d = state_q;
    mem_r   = 1'b0;
    mem_w   = 1'b0;
    c0_ack  = 1'b0;
    c1_ack  = 1'b0;
    busy    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_valid) state_d = pick_mis ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        busy  = 1'b1;
        mem_r = ~cmd_q.wr;
        mem_w = cmd_q.wr;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        busy    = 1'b1;
        c0_ack  = ~gnt_q;
        c1_ack  = gnt_q;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A rejected misaligned command leaves the memory-side fields at their previous values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_q    <= '0;
      gnt_q    <= 1'b0;
      last_q   <= 1'b1;
      err_q    <= 1'b0;
      cnt_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      if ((state_q == ST_IDLE) && arb_valid) begin
        gnt_q  <= arb_gnt;
        last_q <= arb_gnt;
        err_q  <= pick_mis;
        cnt_q  <= CNT_W'(MEM_LAT - 1);
        if (!pick_mis) cmd_q <= cmd_pick;
      end
      if (state_q == ST_ACCESS) begin
        if (cnt_q == '0) begin
          if (gnt_q) rdata1_q <= mem_rdata;
          else       rdata0_q <= mem_rdata;
        end else begin
          cnt_q <= cnt_q - CNT_W'(1);
        end
      end
    end
  end

  assign mem_c     = cmd_q.size;
  assign mem_s     = cmd_q.sign;
  assign mem_addr  = cmd_q.addr;
  assign mem_wdata = cmd_q.wdata;
  assign gnt_id    = gnt_q;
  assign c0_rdata  = rdata0_q;
  assign c1_rdata  = rdata1_q;
  assign c0_err    = c0_ack & err_q;
  assign c1_err    = c1_ack & err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte-array memory environment plus a transaction-level reference model.
// Honours MEM_ARB_ALIGN_CHK_EN for the expected misalignment behaviour.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int MEM_LAT   = 2;
  localparam int PRIO_MODE = PRIO_RR;

  logic        clk = 1'b0;
  logic        rst;
  logic        c0_req, c0_wr, c0_sign, c1_req, c1_wr, c1_sign;
  logic [1:0]  c0_size, c1_size;
  logic [31:0] c0_addr, c0_wdata, c1_addr, c1_wdata;
  logic        c0_ack, c0_err, c1_ack, c1_err;
  logic [31:0] c0_rdata, c1_rdata;
  logic        mem_w, mem_r, mem_s, busy, gnt_id;
  logic [1:0]  mem_c;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_fail = 0;
  int m_last = 1;

  always #5 clk = ~clk;

  mem_arbiter #(.MEM_LAT(MEM_LAT), .PRIO_MODE(PRIO_MODE)) dut (
    .clk(clk), .rst(rst),
    .c0_req(c0_req), .c0_wr(c0_wr), .c0_size(c0_size), .c0_sign(c0_sign),
    .c0_addr(c0_addr), .c0_wdata(c0_wdata), .c0_ack(c0_ack), .c0_rdata(c0_rdata), .c0_err(c0_err),
    .c1_req(c1_req), .c1_wr(c1_wr), .c1_size(c1_size), .c1_sign(c1_sign),
    .c1_addr(c1_addr), .c1_wdata(c1_wdata), .c1_ack(c1_ack), .c1_rdata(c1_rdata), .c1_err(c1_err),
    .mem_w(mem_w), .mem_r(mem_r), .mem_c(mem_c), .mem_s(mem_s),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .busy(busy), .gnt_id(gnt_id)
  );

  // Memory environment (256 bytes, little-endian, address wraps)
  logic [7:0] env_mem [256];
  logic [7:0] ref_mem [256];
  logic       pl_en = 1'b0;
  logic [7:0] pl_a, pl_b, ra;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] size, input logic sign);
    case (size)
      MC_HALF: return {{16{sign & w[15]}}, w[15:0]};
      MC_BYTE: return {{24{sign & w[7]}}, w[7:0]};
      default: return w;
    endcase
  endfunction

  always_comb begin
    ra = mem_addr[7:0];
    mem_rdata = extract({env_mem[ra + 8'd3], env_mem[ra + 8'd2], env_mem[ra + 8'd1], env_mem[ra]}, mem_c, mem_s);
  end

  always @(posedge clk) begin
    if (pl_en) env_mem[pl_a] <= pl_b;
    else if (mem_w) begin
      env_mem[mem_addr[7:0]] <= mem_wdata[7:0];
      if (mem_c != MC_BYTE) env_mem[mem_addr[7:0] + 8'd1] <= mem_wdata[15:8];
      if (mem_c == MC_WORD) begin
        env_mem[mem_addr[7:0] + 8'd2] <= mem_wdata[23:16];
        env_mem[mem_addr[7:0] + 8'd3] <= mem_wdata[31:24];
      end
    end
  end

  // Reference model: transaction-level memory image and rules
  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] size, input logic sign);
    logic [7:0] b;
    b = a[7:0];
    return extract({ref_mem[b + 8'd3], ref_mem[b + 8'd2], ref_mem[b + 8'd1], ref_mem[b]}, size, sign);
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] size, input logic [31:0] d);
    int n;
    logic [7:0] b;
    n = (size == MC_WORD) ? 4 : (size == MC_HALF) ? 2 : 1;
    for (int i = 0; i < n; i++) begin
      b = a[7:0] + 8'(i);
      ref_mem[b] = d[8*i +: 8];
    end
  endtask

  function automatic logic mis_f(input logic [1:0] size, input logic [31:0] a);
`ifdef MEM_ARB_ALIGN_CHK_EN
    return ((size == MC_WORD) && (a[1:0] != 2'b00)) || ((size == MC_HALF) && a[0]);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int alone_lat(input logic [1:0] size, input logic [31:0] a);
    return mis_f(size, a) ? 1 : MEM_LAT + 1;
  endfunction

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_a = a; pl_b = d; pl_en = 1'b1;
    ref_mem[a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Drives one command on port p and measures what the arbiter does with it.
  task automatic do_access(input int p, input logic wr, input logic [1:0] size, input logic sign,
                           input logic [31:0] addr, input logic [31:0] wdata,
                           output int lat, output int rcnt, output int wcnt, output logic [31:0] rd,
                           output logic err, output logic ack_after, output logic [31:0] seen_addr,
                           output logic [31:0] seen_wd, output logic [1:0] seen_c, output logic seen_s);
    lat = -1; rcnt = 0; wcnt = 0; rd = '0; err = 1'b0; ack_after = 1'b0;
    seen_addr = '0; seen_wd = '0; seen_c = '0; seen_s = 1'b0;
    @(posedge clk); #1;
    if (p == 0) begin
      c0_wr = wr; c0_size = size; c0_sign = sign; c0_addr = addr; c0_wdata = wdata; c0_req = 1'b1;
    end else begin
      c1_wr = wr; c1_size = size; c1_sign = sign; c1_addr = addr; c1_wdata = wdata; c1_req = 1'b1;
    end
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if ((mem_r || mem_w) && (gnt_id == p[0])) begin
        if (mem_r) rcnt++;
        if (mem_w) wcnt++;
        seen_addr = mem_addr; seen_wd = mem_wdata; seen_c = mem_c; seen_s = mem_s;
      end
      if ((p == 0) ? c0_ack : c1_ack) begin
        lat = k;
        rd  = (p == 0) ? c0_rdata : c1_rdata;
        err = (p == 0) ? c0_err : c1_err;
        break;
      end
    end
    if (p == 0) c0_req = 1'b0; else c1_req = 1'b0;
    @(posedge clk); #1;
    ack_after = (p == 0) ? c0_ack : c1_ack;
  endtask

  int lat, rcnt, wcnt;
  logic [31:0] rd, sa, swd, exp_rd;
  logic err, aa, ss;
  logic [1:0] sc;

  task automatic test_reset();
    rst = 1'b1;
    c0_req = 0; c0_wr = 0; c0_size = 0; c0_sign = 0; c0_addr = 0; c0_wdata = 0;
    c1_req = 0; c1_wr = 0; c1_size = 0; c1_sign = 0; c1_addr = 0; c1_wdata = 0;
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = 8'($urandom);
      ref_mem[i] = env_mem[i];
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got=%0b exp=0", busy); end
    n_cmp++; if (mem_r !== 1'b0) begin n_fail++; $display("FAIL rst_mem_r got=%0b exp=0", mem_r); end
    n_cmp++; if (mem_w !== 1'b0) begin n_fail++; $display("FAIL rst_mem_w got=%0b exp=0", mem_w); end
    n_cmp++; if ({c0_ack, c1_ack} !== 2'b00) begin n_fail++; $display("FAIL rst_ack got=%b exp=00", {c0_ack, c1_ack}); end
    n_cmp++; if (c0_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_c0_rdata got=%h exp=0", c0_rdata); end
    n_cmp++; if (c1_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_c1_rdata got=%h exp=0", c1_rdata); end
    n_cmp++; if (mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr got=%h exp=0", mem_addr); end
    n_cmp++; if (gnt_id !== 1'b0) begin n_fail++; $display("FAIL rst_gnt_id got=%0b exp=0", gnt_id); end
    m_last = 1;
  endtask

  task automatic test_single_load();
    poke(8'h10, 8'hEF); poke(8'h11, 8'hBE); poke(8'h12, 8'hAD); poke(8'h13, 8'hDE);
    exp_rd = ref_load(32'h10, MC_WORD, 1'b0);
    do_access(0, 1'b0, MC_WORD, 1'b0, 32'h10, 32'h0, lat, rcnt, wcnt, rd, err, aa, sa, swd, sc, ss);
    m_last = 0;
    n_cmp++; if (lat !== MEM_LAT + 1) begin n_fail++; $display("FAIL load_lat got=%0d exp=%0d", lat, MEM_LAT + 1); end
    n_cmp++; if (rcnt !== MEM_LAT) begin n_fail++; $display("FAIL load_mem_r_cycles got=%0d exp=%0d", rcnt, MEM_LAT); end
    n_cmp++; if (wcnt !== 0) begin n_fail++; $display("FAIL load_mem_w_cycles got=%0d exp=0", wcnt); end
    n_cmp++; if (sa !== 32'h10) begin n_fail++; $display("FAIL load_addr got=%h exp=10", sa); end
    n_cmp++; if (rd !== 32'hDEADBEEF || rd !== exp_rd) begin n_fail++; $display("FAIL load_rdata got=%h exp=deadbeef", rd); end
    n_cmp++; if (aa !== 1'b0) begin n_fail++; $display("FAIL load_ack_one_cycle got=%0b exp=0", aa); end
    n_cmp++; if (c0_rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL load_rdata_held got=%h exp=deadbeef", c0_rdata); end
  endtask

  task automatic test_store_load();
    do_access(1, 1'b1, MC_WORD, 1'b0, 32'h20, 32'hCAFEF00D, lat, rcnt, wcnt, rd, err, aa, sa, swd, sc, ss);
    ref_store(32'h20, MC_WORD, 32'hCAFEF00D);
    m_last = 1;
    n_cmp++; if (wcnt !== MEM_LAT) begin n_fail++; $display("FAIL store_mem_w_cycles got=%0d exp=%0d", wcnt, MEM_LAT); end
    n_cmp++; if (rcnt !== 0) begin n_fail++; $display("FAIL store_mem_r_cycles got=%0d exp=0", rcnt); end
    n_cmp++; if (swd !== 32'hCAFEF00D) begin n_fail++; $display("FAIL store_wdata got=%h exp=cafef00d", swd); end
    n_cmp++; if (lat !== MEM_LAT + 1) begin n_fail++; $display("FAIL store_lat got=%0d exp=%0d", lat, MEM_LAT + 1); end
    do_access(0, 1'b0, MC_WORD, 1'b0, 32'h20, 32'h0, lat, rcnt, wcnt, rd, err, aa, sa, swd, sc, ss);
    m_last = 0;
    n_cmp++; if (rd !== ref_load(32'h20, MC_WORD, 1'b0)) begin n_fail++; $display("FAIL store_readback got=%h exp=%h", rd, ref_load(32'h20, MC_WORD, 1'b0)); end
  endtask

  task automatic test_byte_sign();
    poke(8'h23, 8'h80);
    do_access(0, 1'b0, MC_BYTE, 1'b1, 32'h23, 32'h0, lat, rcnt, wcnt, rd, err, aa, sa, swd, sc, ss);
    m_last = 0;
    n_cmp++; if (sc !== MC_BYTE) begin n_fail++; $display("FAIL byte_mem_c got=%b exp=%b", sc, MC_BYTE); end
    n_cmp++; if (ss !== 1'b1) begin n_fail++; $display("FAIL byte_mem_s got=%0b exp=1", ss); end
    n_cmp++; if (rd !== 32'hFFFFFF80) begin n_fail++; $display("FAIL byte_rdata got=%h exp=ffffff80", rd); end
  endtask

  task automatic test_contention();
    int ids[4];
    int edges[4];
    int n, exp_id;
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    m_last = 1;
    c0_wr = 0; c0_size = MC_WORD; c0_sign = 0; c0_addr = 32'h10; c0_req = 1'b1;
    c1_wr = 0; c1_size = MC_WORD; c1_sign = 0; c1_addr = 32'h20; c1_req = 1'b1;
    n = 0;
    for (int k = 1; k <= 40 && n < 4; k++) begin
      @(posedge clk); #1;
      if (c0_ack || c1_ack) begin
        ids[n] = c1_ack ? 1 : 0;
        edges[n] = k;
        n++;
      end
    end
    c0_req = 1'b0; c1_req = 1'b0;
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL cont_ack_count got=%0d exp=4", n); end
    for (int i = 0; i < n; i++) begin
      exp_id = (PRIO_MODE == PRIO_FIXED) ? 0 : ((m_last == 0) ? 1 : 0);
      m_last = exp_id;
      n_cmp++; if (ids[i] !== exp_id) begin n_fail++; $display("FAIL cont_grant%0d got=%0d exp=%0d", i, ids[i], exp_id); end
      n_cmp++; if (edges[i] !== (MEM_LAT + 1) + i * (MEM_LAT + 2)) begin
        n_fail++; $display("FAIL cont_time%0d got=%0d exp=%0d", i, edges[i], (MEM_LAT + 1) + i * (MEM_LAT + 2));
      end
    end
    n_cmp++; if (c0_rdata !== ref_load(32'h10, MC_WORD, 1'b0)) begin n_fail++; $display("FAIL cont_c0_rdata got=%h exp=%h", c0_rdata, ref_load(32'h10, MC_WORD, 1'b0)); end
  endtask

  task automatic test_reset_mid();
    int acks;
    @(posedge clk); #1;
    c0_wr = 0; c0_size = MC_WORD; c0_sign = 0; c0_addr = 32'h10; c0_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    n_cmp++; if (mem_r !== 1'b1) begin n_fail++; $display("FAIL rstmid_pre_mem_r got=%0b exp=1", mem_r); end
    #2 rst = 1'b1; c0_req = 1'b0;
    #1;
    n_cmp++; if ({mem_r, mem_w} !== 2'b00) begin n_fail++; $display("FAIL rstmid_strobes got=%b exp=00", {mem_r, mem_w}); end
    @(negedge clk); @(negedge clk); rst = 1'b0;
    acks = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (c0_ack || c1_ack) acks++;
    end
    n_cmp++; if (acks !== 0) begin n_fail++; $display("FAIL rstmid_no_ack got=%0d exp=0", acks); end
    m_last = 1;
    do_access(1, 1'b0, MC_WORD, 1'b0, 32'h20, 32'h0, lat, rcnt, wcnt, rd, err, aa, sa, swd, sc, ss);
    m_last = 1;
    n_cmp++; if (lat !== MEM_LAT + 1) begin n_fail++; $display("FAIL rstmid_after_lat got=%0d exp=%0d", lat, MEM_LAT + 1); end
    n_cmp++; if (rd !== ref_load(32'h20, MC_WORD, 1'b0)) begin n_fail++; $display("FAIL rstmid_after_rdata got=%h exp=%h", rd, ref_load(32'h20, MC_WORD, 1'b0)); end
  endtask

  task automatic test_align();
    logic [31:0] prev;
    do_access(0, 1'b0, MC_WORD, 1'b0, 32'h10, 32'h0, lat, rcnt, wcnt, rd, err, aa, sa, swd, sc, ss);
    prev = ref_load(32'h10, MC_WORD, 1'b0);
    do_access(0, 1'b0, MC_WORD, 1'b0, 32'h12, 32'h0, lat, rcnt, wcnt, rd, err, aa, sa, swd, sc, ss);
    m_last = 0;
`ifdef MEM_ARB_ALIGN_CHK_EN
    n_cmp++; if (lat !== 1) begin n_fail++; $display("FAIL align_lat got=%0d exp=1", lat); end
    n_cmp++; if (rcnt !== 0) begin n_fail++; $display("FAIL align_no_strobe got=%0d exp=0", rcnt); end
    n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL align_err got=%0b exp=1", err); end
    n_cmp++; if (rd !== prev) begin n_fail++; $display("FAIL align_rdata_kept got=%h exp=%h", rd, prev); end
`else
    n_cmp++; if (lat !== MEM_LAT + 1) begin n_fail++; $display("FAIL align_lat got=%0d exp=%0d", lat, MEM_LAT + 1); end
    n_cmp++; if (rcnt !== MEM_LAT) begin n_fail++; $display("FAIL align_strobes got=%0d exp=%0d", rcnt, MEM_LAT); end
    n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL align_err got=%0b exp=0", err); end
    n_cmp++; if (rd !== ref_load(32'h12, MC_WORD, 1'b0)) begin n_fail++; $display("FAIL align_rdata got=%h exp=%h (prev %h)", rd, ref_load(32'h12, MC_WORD, 1'b0), prev); end
`endif
  endtask

  task automatic test_random();
    logic        wr_a [2];
    logic [1:0]  sz_a [2];
    logic        sg_a [2];
    logic [31:0] ad_a [2];
    logic [31:0] wd_a [2];
    int          lat_a [2], rc_a [2], wc_a [2], exl_a [2];
    logic [31:0] rd_a [2], exr_a [2];
    logic        er_a [2], ea_a [2];
    int l0, l1, r0, r1, w0, w1, mode, w, l;
    logic [31:0] d0, d1, x0, x1, x2, x3;
    logic e0, e1, a0, a1, y0, y1;
    logic [1:0] z0, z1;
    for (int it = 0; it < 40; it++) begin
      mode = $urandom_range(0, 2);
      for (int q = 0; q < 2; q++) begin
        wr_a[q] = 1'($urandom_range(0, 1));
        sz_a[q] = 2'($urandom_range(0, 2));
        sg_a[q] = 1'($urandom_range(0, 1));
        ad_a[q] = 32'($urandom_range(0, 255));
        if ($urandom_range(0, 1) == 1) ad_a[q][1:0] = 2'b00;
        wd_a[q] = $urandom;
      end
      if (mode < 2) begin
        w = mode;
        exl_a[w] = alone_lat(sz_a[w], ad_a[w]);
        exr_a[w] = ref_load(ad_a[w], sz_a[w], sg_a[w]);
        do_access(w, wr_a[w], sz_a[w], sg_a[w], ad_a[w], wd_a[w], l0, r0, w0, d0, e0, a0, x0, x1, z0, y0);
        lat_a[w] = l0; rc_a[w] = r0; wc_a[w] = w0; rd_a[w] = d0; er_a[w] = e0; ea_a[w] = a0;
        if (wr_a[w] && !mis_f(sz_a[w], ad_a[w])) ref_store(ad_a[w], sz_a[w], wd_a[w]);
        m_last = w;
        l = w;
      end else begin
        w = (PRIO_MODE == PRIO_FIXED) ? 0 : ((m_last == 0) ? 1 : 0);
        l = 1 - w;
        exl_a[w] = alone_lat(sz_a[w], ad_a[w]);
        exl_a[l] = exl_a[w] + 1 + alone_lat(sz_a[l], ad_a[l]);
        exr_a[w] = ref_load(ad_a[w], sz_a[w], sg_a[w]);
        if (wr_a[w] && !mis_f(sz_a[w], ad_a[w])) ref_store(ad_a[w], sz_a[w], wd_a[w]);
        exr_a[l] = ref_load(ad_a[l], sz_a[l], sg_a[l]);
        if (wr_a[l] && !mis_f(sz_a[l], ad_a[l])) ref_store(ad_a[l], sz_a[l], wd_a[l]);
        fork
          do_access(0, wr_a[0], sz_a[0], sg_a[0], ad_a[0], wd_a[0], l0, r0, w0, d0, e0, a0, x0, x1, z0, y0);
          do_access(1, wr_a[1], sz_a[1], sg_a[1], ad_a[1], wd_a[1], l1, r1, w1, d1, e1, a1, x2, x3, z1, y1);
        join
        lat_a[0] = l0; rc_a[0] = r0; wc_a[0] = w0; rd_a[0] = d0; er_a[0] = e0; ea_a[0] = a0;
        lat_a[1] = l1; rc_a[1] = r1; wc_a[1] = w1; rd_a[1] = d1; er_a[1] = e1; ea_a[1] = a1;
        m_last = l;
      end
      for (int q = 0; q < 2; q++) begin
        if (mode == 2 || q == mode) begin
          n_cmp++; if (lat_a[q] !== exl_a[q]) begin n_fail++; $display("FAIL rnd%0d_p%0d_lat got=%0d exp=%0d", it, q, lat_a[q], exl_a[q]); end
          n_cmp++; if (rc_a[q] !== ((!wr_a[q] && !mis_f(sz_a[q], ad_a[q])) ? MEM_LAT : 0)) begin
            n_fail++; $display("FAIL rnd%0d_p%0d_mem_r got=%0d", it, q, rc_a[q]);
          end
          n_cmp++; if (wc_a[q] !== ((wr_a[q] && !mis_f(sz_a[q], ad_a[q])) ? MEM_LAT : 0)) begin
            n_fail++; $display("FAIL rnd%0d_p%0d_mem_w got=%0d", it, q, wc_a[q]);
          end
          n_cmp++; if (er_a[q] !== mis_f(sz_a[q], ad_a[q])) begin n_fail++; $display("FAIL rnd%0d_p%0d_err got=%0b exp=%0b", it, q, er_a[q], mis_f(sz_a[q], ad_a[q])); end
          n_cmp++; if (ea_a[q] !== 1'b0 && !(mode == 2 && q == w)) begin n_fail++; $display("FAIL rnd%0d_p%0d_ack_width got=%0b exp=0", it, q, ea_a[q]); end
          if (!wr_a[q] && !mis_f(sz_a[q], ad_a[q])) begin
            n_cmp++; if (rd_a[q] !== exr_a[q]) begin n_fail++; $display("FAIL rnd%0d_p%0d_rdata got=%h exp=%h", it, q, rd_a[q], exr_a[q]); end
          end
        end
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_single_load();
    test_store_load();
    test_byte_sign();
    test_contention();
    test_reset_mid();
    test_align();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
